// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the sequential key lock: FSM state encoding,
// maximal-length LFSR tap masks and key-word extraction from the packed key sequence.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    CHECK    = 2'd0,
    UNLOCKED = 2'd1,
    TRAP     = 2'd2
  } lock_state_t;

  localparam int KEY_MAX = 32;
  localparam int SEQ_MAX = 1024;

  // Fibonacci tap masks (bit n-1 set for tap n) of primitive polynomials.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0004_0023;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      25:      lfsr_taps = 32'h0120_0000;
      26:      lfsr_taps = 32'h0200_0023;
      27:      lfsr_taps = 32'h0400_0013;
      28:      lfsr_taps = 32'h0900_0000;
      29:      lfsr_taps = 32'h1400_0000;
      30:      lfsr_taps = 32'h2000_0029;
      31:      lfsr_taps = 32'h4800_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_0000;
    endcase
  endfunction

  // Word i of a packed sequence of k-bit words, zero-extended to KEY_MAX bits.
  function automatic logic [KEY_MAX-1:0] key_word(input logic [SEQ_MAX-1:0] seq,
                                                  input int k, input int i);
    logic [KEY_MAX-1:0] m;
    m = (k >= KEY_MAX) ? {KEY_MAX{1'b1}} : ((KEY_MAX'(1) << k) - KEY_MAX'(1));
    return KEY_MAX'(seq >> (i * k)) & m;
  endfunction

endpackage

// File: rtl/seq_lock_lfsr.sv
// Free-running W-bit Fibonacci LFSR used as the locked-state output mask.
// Only built when LOCK_LFSR_EN is defined.
`ifdef LOCK_LFSR_EN
module seq_lock_lfsr
  import seq_lock_pkg::*;
#(
  parameter int              W    = 8,
  parameter logic [W-1:0]    SEED = 8'h01
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         en,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  // Shift in the tap parity while enabled, hold otherwise.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[W-2:0], ^(state & TAPS)};
    end else begin
      state <= state;
    end
  end

endmodule
`endif

// File: rtl/seq_key_lock.sv
// Sequential logic-locking wrapper: a D-word key-sequence FSM gating W XOR/XNOR key gates.
// Define LOCK_LFSR_EN to scramble locked outputs with an LFSR mask instead of plain inversion.
module seq_key_lock
  import seq_lock_pkg::*;
#(
  parameter int             W        = 8,
  parameter int             K        = 8,
  parameter int             D        = 4,
  parameter logic [D*K-1:0] KEY_SEQ  = {8'hC3, 8'h5A, 8'h3C, 8'hA5},
  parameter logic [W-1:0]   GATE_POL = 8'h00,
  parameter logic [W-1:0]   SEED     = 8'h01
) (
  input  logic         CK,
  input  logic         RST,
  input  logic [K-1:0] keyinput,
  input  logic         key_valid,
  input  logic [W-1:0] func_out,
  output logic [W-1:0] obf_out,
  output logic         unlocked,
  output logic         lock_err
);

  localparam int IW = (D > 1) ? $clog2(D) : 1;

  if (D < 1) begin : g_bad_depth
    $error("seq_key_lock: D must be at least 1");
  end
  if (SEED == {W{1'b0}}) begin : g_bad_seed
    $error("seq_key_lock: SEED must be nonzero");
  end

  lock_state_t        state_r, state_nx;
  logic [IW-1:0]      idx_r, idx_nx;
  logic [KEY_MAX-1:0] word_s;
  logic               key_hit_s;
  logic [W-1:0]       kbit_s, g_s, mask_s;

  assign word_s    = key_word(SEQ_MAX'(KEY_SEQ), K, int'(idx_r));
  assign key_hit_s = (KEY_MAX'(keyinput) == word_s);

  // Next-state logic; any unknown encoding falls into TRAP.
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    case (state_r)
      CHECK: begin
        if (key_valid) begin
          if (key_hit_s) begin
            if (idx_r == IW'(D - 1)) begin
              state_nx = UNLOCKED;
            end else begin
              idx_nx = idx_r + IW'(1);
            end
          end else begin
            state_nx = TRAP;
          end
        end else begin
          state_nx = CHECK;
        end
      end
      UNLOCKED: state_nx = UNLOCKED;
      TRAP:     state_nx = TRAP;
      default:  state_nx = TRAP;
    endcase
  end

  // The polarity terms cancel, so locked outputs are inverted whatever GATE_POL is.
  assign kbit_s = GATE_POL ^ {W{~unlocked}};
  assign g_s    = func_out ^ kbit_s ^ GATE_POL;

`ifdef LOCK_LFSR_EN
  logic [W-1:0] lfsr_s;

  seq_lock_lfsr #(
    .W    (W),
    .SEED (SEED)
  ) u_lfsr (
    .CK    (CK),
    .RST   (RST),
    .en    (~unlocked),
    .state (lfsr_s)
  );

  assign mask_s = unlocked ? {W{1'b0}} : lfsr_s;
`else
  assign mask_s = {W{1'b0}};
`endif

  // State, flags and protected outputs; flags decode the next state so they track it exactly.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_r  <= CHECK;
      idx_r    <= {IW{1'b0}};
      unlocked <= 1'b0;
      lock_err <= 1'b0;
      obf_out  <= {W{1'b0}};
    end else begin
      state_r  <= state_nx;
      idx_r    <= idx_nx;
      unlocked <= (state_nx == UNLOCKED);
      lock_err <= (state_nx == TRAP);
      obf_out  <= g_s ^ mask_s;
    end
  end

endmodule

// File: tb/tb_seq_key_lock.sv
// Bench for seq_key_lock: directed scenarios plus randomized key traffic against a
// sequence-history reference model. Exercises the LFSR mask when LOCK_LFSR_EN is defined.
module tb_seq_key_lock;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] keyinput = 8'h00;
  logic       key_valid = 1'b0;
  logic [7:0] func_out = 8'h00;
  logic [7:0] obf_out;
  logic       unlocked, lock_err;

  logic [7:0] key2 = 8'h00;
  logic       kv2 = 1'b0;
  logic [7:0] func2 = 8'h00;
  logic [7:0] obf2;
  logic       unl2, err2;

  always #5 CK = ~CK;

  seq_key_lock #(
    .W(8), .K(8), .D(4), .KEY_SEQ(32'hC35A_3CA5), .GATE_POL(8'h00), .SEED(8'h01)
  ) u_dut (
    .CK(CK), .RST(RST), .keyinput(keyinput), .key_valid(key_valid),
    .func_out(func_out), .obf_out(obf_out), .unlocked(unlocked), .lock_err(lock_err)
  );

  seq_key_lock #(
    .W(8), .K(8), .D(1), .KEY_SEQ(8'h77), .GATE_POL(8'hFF), .SEED(8'h01)
  ) u_pol (
    .CK(CK), .RST(RST), .keyinput(key2), .key_valid(kv2),
    .func_out(func2), .obf_out(obf2), .unlocked(unl2), .lock_err(err2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the key words accepted since reset decide the lock status.
  logic [7:0] key_words [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
  logic [7:0] hist [$];
  logic [7:0] lfsr_m = 8'h01;
  logic [7:0] exp_obf;

  // 0 = still checking, 1 = unlocked, 2 = trapped
  function automatic int status();
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i] !== key_words[i]) return 2;
    end
    return (hist.size() == 4) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    lfsr_m = 8'h01;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    key_valid = 1'b0;
    kv2 = 1'b0;
    #2;
    check("rst_obf", obf_out, 8'h00);
    check("rst_unlocked", {7'b0, unlocked}, 8'h00);
    check("rst_lock_err", {7'b0, lock_err}, 8'h00);
    check("rst_pol_obf", obf2, 8'h00);
    @(posedge CK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One clock of the main DUT with model prediction and checks afterwards.
  task automatic step(input logic kv, input logic [7:0] kw, input logic [7:0] fo);
    int st;
    logic [7:0] mask;
    st = status();
    key_valid = kv;
    keyinput  = kw;
    func_out  = fo;
`ifdef LOCK_LFSR_EN
    mask = (st == 1) ? 8'h00 : lfsr_m;
    if (st != 1) lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
    mask = 8'h00;
`endif
    exp_obf = (st == 1) ? fo : (~fo ^ mask);
    if (kv && st == 0) hist.push_back(kw);
    @(posedge CK);
    #1;
    st = status();
    check("obf_out", obf_out, exp_obf);
    check("unlocked", {7'b0, unlocked}, 8'(st == 1));
    check("lock_err", {7'b0, lock_err}, 8'(st == 2));
  endtask

`ifdef LOCK_LFSR_EN
  bit seen [256];
`endif

  initial begin
    // Correct sequence unlocks; unlock edge still shows the locked value.
    do_reset();
    step(1'b1, 8'hA5, 8'h00);
    step(1'b1, 8'h3C, 8'h00);
    step(1'b1, 8'h5A, 8'h00);
    step(1'b1, 8'hC3, 8'h12);
    step(1'b0, 8'h00, 8'h6E);
    check("t1_obf_6e", obf_out, 8'h6E);
    step(1'b1, 8'h00, 8'h00);

    // Wrong second word traps; later correct words are ignored.
    do_reset();
    step(1'b1, 8'hA5, 8'h00);
    step(1'b1, 8'h00, 8'h00);
    step(1'b1, 8'h3C, 8'h00);
    step(1'b1, 8'h5A, 8'h00);
    step(1'b1, 8'hC3, 8'h00);
    step(1'b0, 8'h00, 8'h0F);
`ifndef LOCK_LFSR_EN
    check("t2_obf_f0", obf_out, 8'hF0);
`endif

    // Idle gaps keep progress.
    do_reset();
    step(1'b1, 8'hA5, 8'h33);
    step(1'b0, 8'h3C, 8'h44);
    step(1'b0, 8'h00, 8'h55);
    step(1'b1, 8'h3C, 8'h66);
    step(1'b0, 8'h5A, 8'h77);
    step(1'b1, 8'h5A, 8'h88);
    step(1'b1, 8'hC3, 8'h99);
    check("t3_unlocked", {7'b0, unlocked}, 8'h01);

    // Asynchronous reset mid-sequence restarts the sequence.
    do_reset();
    step(1'b1, 8'hA5, 8'h00);
    step(1'b1, 8'h3C, 8'h00);
    #2 RST = 1'b1;
    #1;
    check("t4_async_obf", obf_out, 8'h00);
    check("t4_async_unl", {7'b0, unlocked}, 8'h00);
    RST = 1'b0;
    model_reset();
    #2;
    step(1'b1, 8'h5A, 8'h00);
    step(1'b1, 8'hC3, 8'h00);
    check("t4_trap", {7'b0, lock_err}, 8'h01);
    do_reset();
    step(1'b1, 8'hA5, 8'h00);
    step(1'b1, 8'h3C, 8'h00);
    step(1'b1, 8'h5A, 8'h00);
    step(1'b1, 8'hC3, 8'h00);
    check("t4_rerun_unl", {7'b0, unlocked}, 8'h01);

    // XNOR gates, single-word key.
    do_reset();
    kv2 = 1'b1;
    key2 = 8'h77;
    func2 = 8'h55;
    step(1'b0, 8'h00, 8'h00);
    kv2 = 1'b0;
    check("t5_unlocked", {7'b0, unl2}, 8'h01);
    check("t5_lock_err", {7'b0, err2}, 8'h00);
`ifndef LOCK_LFSR_EN
    check("t5_locked_obf", obf2, 8'hAA);
`endif
    step(1'b0, 8'h00, 8'h00);
    check("t5_obf_55", obf2, 8'h55);

`ifdef LOCK_LFSR_EN
    // Locked mask walks a maximal-length sequence, then freezes on unlock.
    do_reset();
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 8'h00, 8'h00);
      if (i == 0) check("t6_first", obf_out, 8'hFE);
      check("t6_norepeat", {7'b0, seen[obf_out]}, 8'h00);
      seen[obf_out] = 1'b1;
    end
    step(1'b1, 8'hA5, 8'h00);
    step(1'b1, 8'h3C, 8'h00);
    step(1'b1, 8'h5A, 8'h00);
    step(1'b1, 8'hC3, 8'h00);
    step(1'b0, 8'h00, 8'h3D);
    step(1'b0, 8'h00, 8'hC2);
`endif

    // Randomized key traffic, mostly correct words so unlocks do occur.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        logic       kv;
        logic [7:0] kw;
        kv = ($urandom_range(0, 2) != 0);
        if (hist.size() < 4 && $urandom_range(0, 7) != 0) kw = key_words[hist.size()];
        else kw = 8'($urandom);
        step(kv, kw, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
